// File: rtl/i2s_rx.sv
// i2s_rx: Philips-format I2S receiver, oversampled on clk_in, delivering stereo DATA_WIDTH-bit pairs.
// Define I2S_RX_ERR_EN to enable frame_error_out pulses on short slots; otherwise it is tied low.
module i2s_rx #(
  parameter int DATA_WIDTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk_in,
  input  logic                  reset_in,
  input  logic                  i2s_bclk_in,
  input  logic                  i2s_ws_in,
  input  logic                  i2s_d_in,
  output logic [DATA_WIDTH-1:0] left_out,
  output logic [DATA_WIDTH-1:0] right_out,
  output logic                  data_valid_out,
  output logic                  frame_error_out
);

  // state      | meaning
  // S_PRIME    | after reset, first sampled edge only seeds ws_prev
  // S_UNLOCKED | waiting for the first WS change; partial slot ignored
  // S_LOCKED   | slot capture and pair reporting active

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    S_PRIME    = 2'd0,
    S_UNLOCKED = 2'd1,
    S_LOCKED   = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] bclk_sync, ws_sync, d_sync;
  logic                   bclk_d, bclk_rise;
  logic                   edge_q, ws_q, d_q;
  state_t                 state, state_nxt;
  logic                   ws_prev, boundary;
  logic [CNT_W-1:0]       bit_cnt;
  logic [DATA_WIDTH-1:0]  shift_reg, left_hold, slot_word;
  logic                   left_ok, slot_done, slot_short;

  assign bclk_rise = bclk_sync[SYNC_STAGES-1] & ~bclk_d;

  // Edge event and the WS/SD bits it carries are registered together.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      bclk_sync <= '0;
      ws_sync   <= '0;
      d_sync    <= '0;
      bclk_d    <= 1'b0;
      edge_q    <= 1'b0;
      ws_q      <= 1'b0;
      d_q       <= 1'b0;
    end else begin
      bclk_sync <= {bclk_sync[SYNC_STAGES-2:0], i2s_bclk_in};
      ws_sync   <= {ws_sync[SYNC_STAGES-2:0], i2s_ws_in};
      d_sync    <= {d_sync[SYNC_STAGES-2:0], i2s_d_in};
      bclk_d    <= bclk_sync[SYNC_STAGES-1];
      edge_q    <= bclk_rise;
      ws_q      <= ws_sync[SYNC_STAGES-1];
      d_q       <= d_sync[SYNC_STAGES-1];
    end
  end

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) state <= S_PRIME;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    boundary   = ws_q ^ ws_prev;
    slot_done  = 1'b0;
    slot_short = 1'b0;
    slot_word  = (bit_cnt == CNT_LAST) ? {shift_reg[DATA_WIDTH-2:0], d_q} : shift_reg;
    case (state)
      S_PRIME:    if (edge_q) state_nxt = S_UNLOCKED;
      S_UNLOCKED: if (edge_q && boundary) state_nxt = S_LOCKED;
      S_LOCKED: begin
        if (edge_q && boundary) begin
          if (bit_cnt == CNT_LAST || bit_cnt == CNT_FULL) slot_done = 1'b1;
          else                                            slot_short = 1'b1;
        end
      end
      default:    state_nxt = S_PRIME;
    endcase
  end

  // The bit sampled at a boundary edge belongs to the slot that is ending.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      ws_prev        <= 1'b0;
      bit_cnt        <= '0;
      shift_reg      <= '0;
      left_hold      <= '0;
      left_ok        <= 1'b0;
      left_out       <= '0;
      right_out      <= '0;
      data_valid_out <= 1'b0;
    end else begin
      data_valid_out <= 1'b0;
      if (edge_q) begin
        ws_prev <= ws_q;
        if (boundary) begin
          bit_cnt   <= '0;
          shift_reg <= '0;
        end else if (state == S_LOCKED && bit_cnt < CNT_FULL) begin
          shift_reg <= {shift_reg[DATA_WIDTH-2:0], d_q};
          bit_cnt   <= bit_cnt + 1'b1;
        end
        if (slot_done) begin
          if (!ws_prev) begin
            left_hold <= slot_word;
            left_ok   <= 1'b1;
          end else if (left_ok) begin
            left_out       <= left_hold;
            right_out      <= slot_word;
            data_valid_out <= 1'b1;
            left_ok        <= 1'b0;
          end
        end
        if (slot_short) left_ok <= 1'b0;
      end
    end
  end

`ifdef I2S_RX_ERR_EN
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) frame_error_out <= 1'b0;
    else           frame_error_out <= slot_short;
  end
`else
  assign frame_error_out = 1'b0;
`endif

endmodule

// File: tb/tb_i2s_rx.sv
// tb_i2s_rx: table-driven and randomized frames for i2s_rx, checked against a queue-based slot model.
module tb_i2s_rx;
  localparam int DW = 16;
  localparam int SS = 2;
`ifdef I2S_RX_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic          clk_in = 1'b0;
  logic          reset_in = 1'b0;
  logic          bclk = 1'b0;
  logic          ws = 1'b0;
  logic          sd = 1'b0;
  logic [DW-1:0] left_out, right_out;
  logic          data_valid_out, frame_error_out;

  i2s_rx #(.DATA_WIDTH(DW), .SYNC_STAGES(SS)) dut (
    .clk_in          (clk_in),
    .reset_in        (reset_in),
    .i2s_bclk_in     (bclk),
    .i2s_ws_in       (ws),
    .i2s_d_in        (sd),
    .left_out        (left_out),
    .right_out       (right_out),
    .data_valid_out  (data_valid_out),
    .frame_error_out (frame_error_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct { bit ws; bit sd; } edge_t;
  typedef struct { bit is_err; logic [DW-1:0] l; logic [DW-1:0] r; int rise; } exp_t;
  typedef struct {
    int len_l; int len_r; logic [DW-1:0] l; logic [DW-1:0] r;
    bit pad_l; bit pad_r; int rst_at; int halt_at; int exp_v; int exp_e;
  } vec_t;

  edge_t edges[$];
  exp_t  exp_q[$];
  int    valid_cyc[$];
  int    checks = 0, failures = 0, cyc = 0, half = 3, n_valid = 0, n_err = 0;

  bit            m_primed, m_locked, m_ws_prev, m_left_ok;
  bit            m_bits[$];
  logic [DW-1:0] m_hold, m_last_l, m_last_r;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  function automatic void model_reset();
    m_primed = 0; m_locked = 0; m_ws_prev = 0; m_left_ok = 0;
    m_bits.delete(); exp_q.delete();
    m_hold = '0; m_last_l = '0; m_last_r = '0;
  endfunction

  // Slot-level reference: collect bits of a slot, judge it by length when WS changes.
  function automatic void model_edge(bit w, bit d, int rise);
    logic [DW-1:0] v;
    exp_t e;
    if (!m_primed) begin
      m_primed = 1; m_ws_prev = w;
      return;
    end
    if (w == m_ws_prev) begin
      if (m_locked) m_bits.push_back(d);
    end else if (!m_locked) begin
      m_locked = 1; m_bits.delete();
    end else begin
      m_bits.push_back(d);
      if (m_bits.size() >= DW) begin
        v = '0;
        for (int k = 0; k < DW; k++) v = v * 2 + DW'(m_bits[k]);
        if (!m_ws_prev) begin
          m_hold = v; m_left_ok = 1;
        end else if (m_left_ok) begin
          m_last_l = m_hold; m_last_r = v; m_left_ok = 0;
          e.is_err = 0; e.l = m_hold; e.r = v; e.rise = rise;
          exp_q.push_back(e);
        end
      end else begin
        m_left_ok = 0;
        if (ERR_EN) begin
          e.is_err = 1; e.l = m_last_l; e.r = m_last_r; e.rise = rise;
          exp_q.push_back(e);
        end
      end
      m_bits.delete();
    end
    m_ws_prev = w;
  endfunction

  function automatic void add_slot(bit side, logic [DW-1:0] val, int len, bit pad);
    edge_t e;
    for (int k = 0; k < len; k++) begin
      e.sd = (k < DW) ? val[DW-1-k] : pad;
      e.ws = (k < len - 1) ? side : ~side;
      edges.push_back(e);
    end
  endfunction

  task automatic reset_mid();
    reset_in = 1'b0;
    #1;
    check("reset_mid_left", left_out, 0);
    check("reset_mid_right", right_out, 0);
    model_reset();
    repeat (3) @(negedge clk_in);
    reset_in = 1'b1;
  endtask

  task automatic play(input int rst_at, input int halt_at);
    for (int i = 0; i < edges.size(); i++) begin
      if (i == halt_at) repeat (1000) @(negedge clk_in);
      if (i == rst_at) reset_mid();
      @(negedge clk_in);
      ws = edges[i].ws;
      sd = edges[i].sd;
      repeat (half - 1) @(negedge clk_in);
      bclk = 1'b1;
      model_edge(edges[i].ws, edges[i].sd, cyc);
      repeat (half) @(negedge clk_in);
      bclk = 1'b0;
    end
    edges.delete();
  endtask

  task automatic idle();
    repeat (SS + 8) @(negedge clk_in);
  endtask

  // Every output pulse is matched against the model's next expected event.
  initial begin
    exp_t e;
    int lat;
    forever begin
      @(posedge clk_in);
      cyc++;
      #1;
      if (data_valid_out || frame_error_out) begin
        if (data_valid_out) begin n_valid++; valid_cyc.push_back(cyc); end
        if (frame_error_out) n_err++;
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", {data_valid_out, frame_error_out}, 0);
        end else begin
          e = exp_q.pop_front();
          lat = cyc - e.rise;
          check("pulse_kind", {data_valid_out, frame_error_out}, e.is_err ? 2'b01 : 2'b10);
          check("pulse_left", left_out, e.l);
          check("pulse_right", right_out, e.r);
          check("pulse_latency_window", (lat >= SS + 1 && lat <= SS + 3), 1);
        end
      end
    end
  end

  initial begin
    vec_t tbl[10];
    int v0, e0, lr, rr;
    tbl[0] = '{16, 16, 16'h1234, 16'hABCD, 0, 0, -1, -1, 0, 0};
    tbl[1] = '{16, 16, 16'h1234, 16'hABCD, 0, 0, -1, -1, 1, 0};
    tbl[2] = '{32, 32, 16'h8001, 16'h7FFE, 1, 0, -1, -1, 1, 0};
    tbl[3] = '{10, 16, 16'h3C3C, 16'h5555, 0, 0, -1, -1, 0, 1};
    tbl[4] = '{16, 16, 16'h0F0F, 16'hF0F0, 0, 0, -1, -1, 1, 0};
    tbl[5] = '{16, 16, 16'h1111, 16'h2222, 0, 0, 21, -1, 0, 0};
    tbl[6] = '{16, 16, 16'h1357, 16'h2468, 0, 0, -1, -1, 1, 0};
    tbl[7] = '{16, 16, 16'hCAFE, 16'hBEEF, 0, 0, -1, 5, 1, 0};
    tbl[8] = '{16, 12, 16'h0001, 16'hFFFF, 0, 0, -1, -1, 0, 1};
    tbl[9] = '{24, 17, 16'h8000, 16'h7FFF, 1, 1, -1, -1, 1, 0};

    model_reset();
    repeat (3) @(negedge clk_in);
    check("reset_left", left_out, 0);
    check("reset_right", right_out, 0);
    check("reset_valid", data_valid_out, 0);
    check("reset_error", frame_error_out, 0);
    reset_in = 1'b1;
    repeat (2) @(negedge clk_in);

    for (int i = 0; i < 10; i++) begin
      v0 = n_valid; e0 = n_err;
      add_slot(1'b0, tbl[i].l, tbl[i].len_l, tbl[i].pad_l);
      add_slot(1'b1, tbl[i].r, tbl[i].len_r, tbl[i].pad_r);
      play(tbl[i].rst_at, tbl[i].halt_at);
      idle();
      check($sformatf("tbl%0d_valid_count", i), n_valid - v0, tbl[i].exp_v);
      check($sformatf("tbl%0d_error_count", i), n_err - e0, ERR_EN ? tbl[i].exp_e : 0);
      check($sformatf("tbl%0d_left_hold", i), left_out, m_last_l);
      check($sformatf("tbl%0d_right_hold", i), right_out, m_last_r);
    end
    check("tbl_final_left", left_out, 16'h8000);
    check("tbl_final_right", right_out, 16'h7FFF);

    // Back-to-back frames at the minimum BCLK ratio.
    half = 3;
    v0 = n_valid;
    valid_cyc.delete();
    for (int f = 0; f < 8; f++) begin
      add_slot(1'b0, DW'(16'h1000 + 2 * f), 16, 1'b0);
      add_slot(1'b1, DW'(16'h1001 + 2 * f), 16, 1'b0);
    end
    play(-1, -1);
    idle();
    check("burst_valid_count", n_valid - v0, 8);
    check("burst_last_left", left_out, 16'h100E);
    check("burst_last_right", right_out, 16'h100F);
    for (int k = 1; k < valid_cyc.size(); k++)
      check($sformatf("burst_spacing%0d", k), valid_cyc[k] - valid_cyc[k-1], 32 * 2 * 3);

    for (int f = 0; f < 30; f++) begin
      half = $urandom_range(3, 5);
      lr = ($urandom_range(0, 4) == 0) ? $urandom_range(4, 15) : $urandom_range(16, 40);
      rr = ($urandom_range(0, 4) == 0) ? $urandom_range(4, 15) : $urandom_range(16, 40);
      add_slot(1'b0, DW'($urandom), lr, 1'($urandom));
      add_slot(1'b1, DW'($urandom), rr, 1'($urandom));
      play(-1, -1);
      idle();
      check($sformatf("rand%0d_left_hold", f), left_out, m_last_l);
      check($sformatf("rand%0d_right_hold", f), right_out, m_last_r);
    end

    check("pending_expected", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
